// File: rtl/multi_event_monitor_if.sv
// Bundle of the event inputs and alarm/status outputs of multi_event_monitor.
//
// Configuration: when MONITOR_IRQ_PULSE_EN is defined, the bundle also carries
// the single-cycle irq pulse.
//
// Signals:
//   evnt      [NCH]  per-channel event strobe (source -> monitor)
//   clr       [NCH]  per-channel alarm/count clear (source -> monitor)
//   mode             0 = consecutive, 1 = cumulative counting (source -> monitor)
//   thresh    [CW]   shared threshold; alarm when count > thresh (source -> monitor)
//   alarm     [NCH]  per-channel sticky alarm (monitor -> sink)
//   any_alarm        OR of alarm (monitor -> sink)
//   first_vld        first_ch is valid (monitor -> sink)
//   first_ch  [IW]   channel that opened the current alarm episode (monitor -> sink)
//   irq              one-cycle pulse on any new alarm (MONITOR_IRQ_PULSE_EN only)
//
// Modports: master = event source / status consumer, slave = the monitor.
interface multi_event_monitor_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 6
);
  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] evnt;
  logic [NCH-1:0] clr;
  logic           mode;
  logic [CW-1:0]  thresh;
  logic [NCH-1:0] alarm;
  logic           any_alarm;
  logic           first_vld;
  logic [IW-1:0]  first_ch;
`ifdef MONITOR_IRQ_PULSE_EN
  logic           irq;
`endif

  modport master (
    output evnt,
    output clr,
    output mode,
    output thresh,
    input  alarm,
    input  any_alarm,
    input  first_vld,
`ifdef MONITOR_IRQ_PULSE_EN
    input  irq,
`endif
    input  first_ch
  );

  modport slave (
    input  evnt,
    input  clr,
    input  mode,
    input  thresh,
    output alarm,
    output any_alarm,
    output first_vld,
`ifdef MONITOR_IRQ_PULSE_EN
    output irq,
`endif
    output first_ch
  );

endinterface

// File: rtl/multi_event_monitor.sv
// Multi-channel event monitor with sticky per-channel alarms.
//
// Each of NCH channels counts events (consecutive or cumulative, selected by
// mode) in a saturating CW-bit counter. When an event pushes the count above
// the shared threshold, the channel alarm sets and stays set (count frozen)
// until that channel's clr or reset. A summary stage reports any_alarm and the
// lowest-indexed channel that opened the current alarm episode.
//
// Configuration: define MONITOR_IRQ_PULSE_EN to add a registered irq output
// that pulses for one cycle after any edge where an alarm bit rises.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  multi_event_monitor_if slave modport (evnt, clr, mode, thresh in;
//        alarm, any_alarm, first_vld, first_ch [, irq] out)
module multi_event_monitor #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 6
) (
  input logic                  clk,
  input logic                  rst,
  multi_event_monitor_if.slave bus
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] CntMax = {CW{1'b1}};

  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] alarm_q, alarm_d;
  logic [NCH-1:0] rise;
  logic           first_vld_q, first_vld_d;
  logic [IW-1:0]  first_ch_q, first_ch_d;
  logic           found;
`ifdef MONITOR_IRQ_PULSE_EN
  logic           irq_q, irq_d;
`endif

  // Per-channel counter and alarm next state, in priority order:
  // clear, frozen-while-alarmed, event, idle.
  always_comb begin
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (bus.clr[i]) begin
        cnt_d[i]   = '0;
        alarm_d[i] = 1'b0;
      end else if (alarm_q[i]) begin
        // Alarmed channel ignores evnt and mode; count stays frozen.
        cnt_d[i]   = cnt_q[i];
      end else if (bus.evnt[i]) begin
        cnt_d[i] = (cnt_q[i] == CntMax) ? CntMax : cnt_q[i] + CW'(1);
        // Only an event edge can trip the alarm; a threshold lowered below
        // a held count waits for the next event.
        if (cnt_d[i] > bus.thresh) begin
          alarm_d[i] = 1'b1;
        end
      end else if (!bus.mode) begin
        cnt_d[i] = '0;
      end
    end
  end

  assign rise = alarm_d & ~alarm_q;

  // Episode tracking. A new episode starts when alarms exist after the edge
  // but none of them survive from before it (covers both the idle case and
  // the last alarm being cleared while another rises on the same edge).
  always_comb begin
    first_vld_d = first_vld_q;
    first_ch_d  = first_ch_q;
    found       = 1'b0;
    if (alarm_d == '0) begin
      first_vld_d = 1'b0;
      first_ch_d  = '0;
    end else if ((alarm_d & alarm_q) == '0) begin
      first_vld_d = 1'b1;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (rise[i] && !found) begin
          first_ch_d = IW'(i);
          found      = 1'b1;
        end
      end
    end
  end

`ifdef MONITOR_IRQ_PULSE_EN
  assign irq_d = |rise;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      alarm_q     <= '0;
      first_vld_q <= 1'b0;
      first_ch_q  <= '0;
`ifdef MONITOR_IRQ_PULSE_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      alarm_q     <= alarm_d;
      first_vld_q <= first_vld_d;
      first_ch_q  <= first_ch_d;
`ifdef MONITOR_IRQ_PULSE_EN
      irq_q       <= irq_d;
`endif
    end
  end

  assign bus.alarm     = alarm_q;
  assign bus.any_alarm = |alarm_q;
  assign bus.first_vld = first_vld_q;
  assign bus.first_ch  = first_ch_q;
`ifdef MONITOR_IRQ_PULSE_EN
  assign bus.irq       = irq_q;
`endif

  // first_vld is exactly "some alarm is set"; first_ch idles at zero.
  assert property (@(posedge clk) first_vld_q == (|alarm_q));
  assert property (@(posedge clk) !first_vld_q |-> (first_ch_q == '0));

endmodule

// File: tb/tb_multi_event_monitor.sv
// Self-checking bench for multi_event_monitor: table-driven directed vectors,
// hand-written corner sequences and randomized stimulus against a reference
// model. Honours MONITOR_IRQ_PULSE_EN when defined.
module tb_multi_event_monitor;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 6;
  localparam int MaxCnt = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multi_event_monitor_if #(.NCH(NCH), .CW(CW)) bus ();

  multi_event_monitor #(.NCH(NCH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int         m_cnt [NCH];
  logic [3:0] m_alarm;
  logic       m_fv;
  logic [1:0] m_fc;
  logic       m_irq;

  typedef struct {
    logic       r;
    logic [3:0] ev;
    logic [3:0] cl;
    logic       md;
    logic [5:0] th;
    logic [3:0] exp_alarm;
    logic       exp_fv;
    logic [1:0] exp_fc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] ev, input logic [3:0] cl,
                            input logic md, input logic [5:0] th);
    logic [3:0] rose;
    rose = '0;
    if (!r) begin
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      m_alarm = '0;
      m_fv    = 1'b0;
      m_fc    = '0;
      m_irq   = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cl[i]) begin
          m_cnt[i]   = 0;
          m_alarm[i] = 1'b0;
        end else if (!m_alarm[i]) begin
          if (ev[i]) begin
            m_cnt[i] = (m_cnt[i] + 1 > MaxCnt) ? MaxCnt : m_cnt[i] + 1;
            if (m_cnt[i] > int'(th)) begin
              m_alarm[i] = 1'b1;
              rose[i]    = 1'b1;
            end
          end else if (!md) begin
            m_cnt[i] = 0;
          end
        end
      end
      m_irq = (rose != 0);
      if (m_alarm == 0) begin
        m_fv = 1'b0;
        m_fc = '0;
      end else if (m_alarm == rose) begin
        // Every alarm now set is brand new: a fresh episode.
        m_fv = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) if (rose[i]) m_fc = 2'(i);
      end
    end
  endtask

  task automatic compare_model();
    chk("alarm", 32'(bus.alarm), 32'(m_alarm));
    chk("any_alarm", 32'(bus.any_alarm), 32'(m_alarm != 0));
    chk("first_vld", 32'(bus.first_vld), 32'(m_fv));
    chk("first_ch", 32'(bus.first_ch), 32'(m_fc));
`ifdef MONITOR_IRQ_PULSE_EN
    chk("irq", 32'(bus.irq), 32'(m_irq));
`endif
  endtask

  task automatic step(input logic r, input logic [3:0] ev, input logic [3:0] cl,
                      input logic md, input logic [5:0] th);
    rst        = r;
    bus.evnt   = ev;
    bus.clr    = cl;
    bus.mode   = md;
    bus.thresh = th;
    @(posedge clk);
    model_edge(r, ev, cl, md, th);
    #1;
    compare_model();
  endtask

  task automatic add(input logic r, input logic [3:0] ev, input logic [3:0] cl,
                     input logic md, input logic [5:0] th, input logic [3:0] ea,
                     input logic efv, input logic [1:0] efc);
    vec_t v;
    v.r = r; v.ev = ev; v.cl = cl; v.md = md; v.th = th;
    v.exp_alarm = ea; v.exp_fv = efv; v.exp_fc = efc;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic [3:0] ev, input logic md);
    for (int k = 0; k < n; k++) add(1, ev, 4'b0, md, 6'd3, 4'b0, 1'b0, 2'd0);
  endtask

  int irq_pulses;

  initial begin
    bus.evnt = '0; bus.clr = '0; bus.mode = 1'b0; bus.thresh = '0;

    // Reset
    add(0, 4'b0000, 4'b0000, 0, 3, 4'b0000, 0, 0);
    // ch0 consecutive trip on 4th event, held, then clear
    add_n(3, 4'b0001, 0);
    add(1, 4'b0001, 4'b0000, 0, 3, 4'b0001, 1, 0);
    add(1, 4'b0001, 4'b0000, 0, 3, 4'b0001, 1, 0);
    add(1, 4'b0000, 4'b0001, 0, 3, 4'b0000, 0, 0);
    // ch1 3 events, gap, 3 events in consecutive mode: never trips
    add_n(3, 4'b0010, 0);
    add_n(1, 4'b0000, 0);
    add_n(3, 4'b0010, 0);
    add(1, 4'b0000, 4'b0010, 0, 3, 4'b0000, 0, 0);
    // Same pattern in cumulative mode trips on 4th event
    add_n(3, 4'b0010, 1);
    add_n(1, 4'b0000, 1);
    add(1, 4'b0010, 4'b0000, 1, 3, 4'b0010, 1, 1);
    add(1, 4'b0000, 4'b0010, 1, 3, 4'b0000, 0, 0);
    // ch3 and ch1 trip together; first_ch survives clr of ch1
    add_n(3, 4'b1010, 0);
    add(1, 4'b1010, 4'b0000, 0, 3, 4'b1010, 1, 1);
    add(1, 4'b0000, 4'b0010, 0, 3, 4'b1000, 1, 1);
    add(1, 4'b0000, 4'b1000, 0, 3, 4'b0000, 0, 0);
    // clr with evnt on same edge loses the event
    add_n(3, 4'b0001, 0);
    add(1, 4'b0001, 4'b0000, 0, 3, 4'b0001, 1, 0);
    add(1, 4'b0001, 4'b0001, 0, 3, 4'b0000, 0, 0);
    add_n(3, 4'b0001, 0);
    // Mid-run reset on ch2 discards its count
    add_n(2, 4'b0100, 0);
    add(0, 4'b0100, 4'b0000, 0, 3, 4'b0000, 0, 0);
    add_n(3, 4'b0100, 0);
    add(1, 4'b0100, 4'b0000, 0, 3, 4'b0100, 1, 2);
    add(0, 4'b0000, 4'b0000, 0, 3, 4'b0000, 0, 0);

    for (int n = 0; n < vecs.size(); n++) begin
      step(vecs[n].r, vecs[n].ev, vecs[n].cl, vecs[n].md, vecs[n].th);
      chk($sformatf("tbl%0d_alarm", n), 32'(bus.alarm), 32'(vecs[n].exp_alarm));
      chk($sformatf("tbl%0d_fv", n), 32'(bus.first_vld), 32'(vecs[n].exp_fv));
      chk($sformatf("tbl%0d_fc", n), 32'(bus.first_ch), 32'(vecs[n].exp_fc));
    end

    // Saturation at thresh = max: never trips
    for (int k = 0; k < 70; k++) step(1, 4'b0100, 4'b0000, 0, 6'd63);
    chk("sat_no_alarm", 32'(bus.alarm), 32'h0);
    // Lowering thresh below the held count waits for the next event
    step(1, 4'b0000, 4'b0000, 1, 6'd62);
    chk("thr_lower_idle", 32'(bus.alarm), 32'h0);
    step(1, 4'b0100, 4'b0000, 1, 6'd62);
    chk("thr_lower_evt", 32'(bus.alarm), 32'h4);
    // Sticky against thresh raise
    step(1, 4'b0000, 4'b0000, 1, 6'd63);
    chk("sticky_thr", 32'(bus.alarm), 32'h4);
    step(1, 4'b0000, 4'b0100, 0, 6'd0);
    // thresh = 0: first event trips
    step(1, 4'b0001, 4'b0000, 0, 6'd0);
    chk("thr0_alarm", 32'(bus.alarm), 32'h1);
    chk("thr0_fc", 32'(bus.first_ch), 32'h0);
    // Last alarm cleared while another rises: new episode on ch3
    step(1, 4'b1000, 4'b0001, 0, 6'd0);
    chk("handover_alarm", 32'(bus.alarm), 32'h8);
    chk("handover_fv", 32'(bus.first_vld), 32'h1);
    chk("handover_fc", 32'(bus.first_ch), 32'h3);

    // Two trips on different edges, then clear and re-trip ch0
    step(0, 4'b0000, 4'b0000, 0, 6'd1);
    irq_pulses = 0;
    for (int k = 0; k < 9; k++) begin
      logic [3:0] ev;
      logic [3:0] cl;
      ev = (k < 2) ? 4'b0001 : (k == 3 || k == 4) ? 4'b0010 : (k >= 6 && k < 8) ? 4'b0001 : 4'b0;
      cl = (k == 5) ? 4'b0001 : 4'b0;
      step(1, ev, cl, 0, 6'd1);
`ifdef MONITOR_IRQ_PULSE_EN
      if (bus.irq) irq_pulses++;
`else
      if (m_irq) irq_pulses++;
`endif
    end
    chk("irq_pulses", 32'(irq_pulses), 32'd3);

    // Randomized run against the model
    for (int k = 0; k < 600; k++) begin
      logic       r;
      logic [3:0] ev;
      logic [3:0] cl;
      logic       md;
      logic [5:0] th;
      r  = ($urandom_range(0, 99) != 0);
      ev = 4'($urandom) | 4'($urandom);
      cl = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
      md = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       th = 6'd63;
        1:       th = 6'd62;
        default: th = 6'($urandom_range(0, 6));
      endcase
      step(r, ev, cl, md, th);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
